// File: rtl/cmd_sequencer.sv
// Command sequencer: accepts 16-bit commands from the UART wrapper, runs calibration,
// square-counted moves or tour starts, and answers with an ACK/NAK byte.
module cmd_sequencer #(
    parameter logic [7:0]  ACK   = 8'hA5,
    parameter logic [7:0]  NAK   = 8'h5A,
    parameter int unsigned TMO_W = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_rdy,
    input  logic [15:0] cmd,
    output logic        clr_cmd_rdy,
    output logic        trmt,
    output logic [7:0]  resp,
    input  logic        tx_done,
    output logic        strt_cal,
    input  logic        cal_done,
    output logic [7:0]  heading,
    output logic        move_en,
    input  logic        sq_done,
    output logic        tour_go,
    output logic [7:0]  tour_pos,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CAL, MOVE, TXW} state_t;

    state_t             state;
    logic [15:0]        cmd_q;
    logic               dec_pend;
    logic [3:0]         sq_cnt;
    logic [3:0]         target;
    logic [TMO_W-1:0]   wdog;
    logic [TMO_W-1:0]   wdog_nxt;
    logic [3:0]         sq_cnt_nxt;
    logic               wdog_exp;

    // Expiry flags the cycle that would bring the count to all-ones, so the
    // timeout spans exactly 2^TMO_W-1 cycles including the first one in state.
    always_comb begin
        wdog_nxt   = wdog + TMO_W'(1);
        sq_cnt_nxt = sq_cnt + 4'd1;
        wdog_exp   = (wdog_nxt == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_q       <= '0;
            dec_pend    <= 1'b0;
            sq_cnt      <= '0;
            target      <= '0;
            wdog        <= '0;
            clr_cmd_rdy <= 1'b0;
            trmt        <= 1'b0;
            resp        <= '0;
            strt_cal    <= 1'b0;
            heading     <= '0;
            move_en     <= 1'b0;
            tour_go     <= 1'b0;
            tour_pos    <= '0;
            busy        <= 1'b0;
        end else begin
            clr_cmd_rdy <= 1'b0;
            trmt        <= 1'b0;
            strt_cal    <= 1'b0;
            tour_go     <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (dec_pend) begin
                        // Decode the latched copy one cycle after acceptance.
                        dec_pend <= 1'b0;
                        busy     <= 1'b1;
                        wdog     <= '0;
                        case (cmd_q[15:12])
                            4'h2: begin
                                strt_cal <= 1'b1;
                                state    <= CAL;
                            end
                            4'h4: begin
                                heading <= cmd_q[11:4];
                                sq_cnt  <= '0;
                                target  <= cmd_q[3:0];
                                if (cmd_q[3:0] == 4'd0) begin
                                    resp  <= ACK;
                                    trmt  <= 1'b1;
                                    state <= TXW;
                                end else begin
                                    move_en <= 1'b1;
                                    state   <= MOVE;
                                end
                            end
                            4'h6: begin
                                tour_pos <= cmd_q[7:0];
                                tour_go  <= 1'b1;
                            end
                            default: begin
                                resp  <= NAK;
                                trmt  <= 1'b1;
                                state <= TXW;
                            end
                        endcase
                    end else if (cmd_rdy) begin
                        clr_cmd_rdy <= 1'b1;
                        cmd_q       <= cmd;
                        dec_pend    <= 1'b1;
                    end
                end
                CAL: begin
                    if (cal_done) begin
                        resp  <= ACK;
                        trmt  <= 1'b1;
                        state <= TXW;
                    end else if (wdog_exp) begin
                        resp  <= NAK;
                        trmt  <= 1'b1;
                        state <= TXW;
                    end else begin
                        wdog <= wdog_nxt;
                    end
                end
                MOVE: begin
                    if (sq_done && (sq_cnt_nxt == target)) begin
                        move_en <= 1'b0;
                        resp    <= ACK;
                        trmt    <= 1'b1;
                        state   <= TXW;
                    end else if (wdog_exp) begin
                        move_en <= 1'b0;
                        resp    <= NAK;
                        trmt    <= 1'b1;
                        state   <= TXW;
                    end else begin
                        wdog <= wdog_nxt;
                        if (sq_done) sq_cnt <= sq_cnt_nxt;
                    end
                end
                TXW: begin
                    if (tx_done && !trmt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer with hand-computed expectations (watchdog width 6).
module tb_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_rdy = 1'b0;
    logic [15:0] cmd = '0;
    logic        clr_cmd_rdy;
    logic        trmt;
    logic [7:0]  resp;
    logic        tx_done = 1'b0;
    logic        strt_cal;
    logic        cal_done = 1'b0;
    logic [7:0]  heading;
    logic        move_en;
    logic        sq_done = 1'b0;
    logic        tour_go;
    logic [7:0]  tour_pos;
    logic        busy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    cmd_sequencer #(.ACK(8'hA5), .NAK(8'h5A), .TMO_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd),
        .clr_cmd_rdy(clr_cmd_rdy), .trmt(trmt), .resp(resp), .tx_done(tx_done),
        .strt_cal(strt_cal), .cal_done(cal_done), .heading(heading),
        .move_en(move_en), .sq_done(sq_done), .tour_go(tour_go),
        .tour_pos(tour_pos), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command, expect the acceptance pulse, then step into the decode cycle.
    task automatic send(input logic [15:0] c);
        cmd     = c;
        cmd_rdy = 1'b1;
        tick();
        check_val("accept_clr", {31'd0, clr_cmd_rdy}, 32'd1);
        check_val("accept_busy", {31'd0, busy}, 32'd0);
        cmd_rdy = 1'b0;
        tick();
        check_val("decode_clr", {31'd0, clr_cmd_rdy}, 32'd0);
    endtask

    task automatic tx_finish();
        tick();
        check_val("trmt_one_cycle", {31'd0, trmt}, 32'd0);
        check_val("txw_busy", {31'd0, busy}, 32'd1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check_val("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int unsigned cnt;
        int unsigned clr_cnt;

        #12;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_outs", {25'd0, clr_cmd_rdy, trmt, strt_cal, move_en, tour_go, 2'b00}, 32'd0);
        check_val("rst_resp", {24'd0, resp}, 32'd0);
        check_val("rst_heading", {24'd0, heading}, 32'd0);
        check_val("rst_tour_pos", {24'd0, tour_pos}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Calibration, cal_done 50 cycles after acceptance.
        send(16'h2000);
        check_val("cal_strt", {31'd0, strt_cal}, 32'd1);
        check_val("cal_busy", {31'd0, busy}, 32'd1);
        tick();
        check_val("cal_strt_pulse", {31'd0, strt_cal}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 48; i++) begin
            tick();
            if (trmt) cnt++;
        end
        check_val("cal_no_early_trmt", cnt, 0);
        cal_done = 1'b1;
        tick();
        cal_done = 1'b0;
        check_val("cal_trmt", {31'd0, trmt}, 32'd1);
        check_val("cal_resp", {24'd0, resp}, 32'hA5);
        tx_finish();

        // Three-square move.
        send(16'h45A3);
        check_val("mv_heading", {24'd0, heading}, 32'h5A);
        check_val("mv_en_start", {31'd0, move_en}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            tick();
            check_val("mv_en_mid", {31'd0, move_en}, 32'd1);
            sq_done = 1'b1;
            tick();
            sq_done = 1'b0;
            if (i < 2) begin
                check_val("mv_en_after_sq", {31'd0, move_en}, 32'd1);
                check_val("mv_no_trmt", {31'd0, trmt}, 32'd0);
            end else begin
                check_val("mv_en_done", {31'd0, move_en}, 32'd0);
                check_val("mv_trmt", {31'd0, trmt}, 32'd1);
                check_val("mv_resp", {24'd0, resp}, 32'hA5);
            end
        end
        tx_finish();

        // Zero-square move answers at once.
        send(16'h4120);
        check_val("mv0_en", {31'd0, move_en}, 32'd0);
        check_val("mv0_trmt", {31'd0, trmt}, 32'd1);
        check_val("mv0_resp", {24'd0, resp}, 32'hA5);
        check_val("mv0_heading", {24'd0, heading}, 32'h12);
        tx_finish();

        // Tour start.
        send(16'h6023);
        check_val("tour_pos", {24'd0, tour_pos}, 32'h23);
        check_val("tour_go", {31'd0, tour_go}, 32'd1);
        check_val("tour_no_trmt", {31'd0, trmt}, 32'd0);
        check_val("tour_busy", {31'd0, busy}, 32'd1);
        tick();
        check_val("tour_go_pulse", {31'd0, tour_go}, 32'd0);
        check_val("tour_busy_low", {31'd0, busy}, 32'd0);
        check_val("tour_heading_held", {24'd0, heading}, 32'h12);

        // Bad opcode; tx_done coinciding with trmt must be ignored.
        send(16'hF000);
        check_val("bad_trmt", {31'd0, trmt}, 32'd1);
        check_val("bad_resp", {24'd0, resp}, 32'h5A);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check_val("early_txdone_busy", {31'd0, busy}, 32'd1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check_val("bad_idle", {31'd0, busy}, 32'd0);

        // Inputs outside their states are ignored.
        cal_done = 1'b1;
        sq_done  = 1'b1;
        tick();
        cal_done = 1'b0;
        sq_done  = 1'b0;
        check_val("stray_busy", {31'd0, busy}, 32'd0);
        check_val("stray_trmt", {31'd0, trmt}, 32'd0);

        // Move with no squares: watchdog expires after 63 cycles.
        send(16'h4002);
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!move_en) break;
            cnt++;
        end
        check_val("tmo_cycles", cnt, 63);
        check_val("tmo_trmt", {31'd0, trmt}, 32'd1);
        check_val("tmo_resp", {24'd0, resp}, 32'h5A);
        tx_finish();

        // Final square in the expiry cycle: completion wins.
        send(16'h4001);
        for (int i = 0; i < 62; i++) tick();
        check_val("race_en", {31'd0, move_en}, 32'd1);
        sq_done = 1'b1;
        tick();
        sq_done = 1'b0;
        check_val("race_trmt", {31'd0, trmt}, 32'd1);
        check_val("race_resp", {24'd0, resp}, 32'hA5);
        tx_finish();

        // Second command while moving waits for IDLE.
        send(16'h4003);
        cmd     = 16'hF000;
        cmd_rdy = 1'b1;
        clr_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (clr_cmd_rdy) clr_cnt++;
            sq_done = 1'b1;
            tick();
            sq_done = 1'b0;
            if (clr_cmd_rdy) clr_cnt++;
        end
        check_val("q_trmt", {31'd0, trmt}, 32'd1);
        tick();
        if (clr_cmd_rdy) clr_cnt++;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        if (clr_cmd_rdy) clr_cnt++;
        check_val("q_no_clr_busy", clr_cnt, 0);
        check_val("q_idle", {31'd0, busy}, 32'd0);
        tick();
        check_val("q_clr", {31'd0, clr_cmd_rdy}, 32'd1);
        cmd_rdy = 1'b0;
        tick();
        check_val("q_trmt2", {31'd0, trmt}, 32'd1);
        check_val("q_resp2", {24'd0, resp}, 32'h5A);
        tx_finish();

        // Reset in the middle of a move.
        send(16'h4075);
        check_val("rm_en", {31'd0, move_en}, 32'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rm_en_abort", {31'd0, move_en}, 32'd0);
        check_val("rm_busy_abort", {31'd0, busy}, 32'd0);
        #10;
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (trmt || move_en || busy) cnt++;
        end
        check_val("rm_quiet", cnt, 0);
        check_val("rm_resp", {24'd0, resp}, 32'd0);
        check_val("rm_heading", {24'd0, heading}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_sequencer.md
CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 Parameter ACK, 8'hA5, positive response byte.
REQ-002 Parameter NAK, 8'h5A, negative response byte (bad opcode or timeout).
REQ-003 Parameter TMO_W, 20, watchdog counter width; timeout = 2^TMO_W-1 cycles.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 cmd_rdy  in  1  16-bit command available from UART command wrapper.
REQ-007 cmd  in  16  command; [15:12] opcode, [11:4] operand, [3:0] square count.
REQ-008 clr_cmd_rdy  out  1  one-cycle pulse consuming current command.
REQ-009 trmt  out  1  one-cycle pulse starting transmission of resp.
REQ-010 resp  out  8  response byte to UART wrapper.
REQ-011 tx_done  in  1  response byte fully transmitted.
REQ-012 strt_cal  out  1  one-cycle pulse starting sensor/gyro calibration.
REQ-013 cal_done  in  1  calibration complete.
REQ-014 heading  out  8  desired heading to motion controller.
REQ-015 move_en  out  1  level; motion controller drives forward while high.
REQ-016 sq_done  in  1  one-cycle pulse per board square crossed.
REQ-017 tour_go  out  1  one-cycle pulse starting tour solver.
REQ-018 tour_pos  out  8  tour start position {x,y} nibbles.
REQ-019 busy  out  1  high whenever state is not IDLE.

Function
REQ-020 States: IDLE, CAL, MOVE, TXW; all outputs registered.
REQ-021 IDLE + cmd_rdy: accept; clr_cmd_rdy high that same cycle only; cmd latched internally; decode on latched copy.
REQ-022 cmd_rdy outside IDLE ignored; clr_cmd_rdy never asserted outside IDLE acceptance cycle.
REQ-023 Opcode 4'h2 (CAL): strt_cal pulse cycle after acceptance; -> CAL; watchdog cleared.
REQ-024 CAL + cal_done: resp<=ACK, trmt pulse next cycle, -> TXW.
REQ-025 Opcode 4'h4 (MOVE): heading<=cmd[11:4], square counter<=0, target<=cmd[3:0], watchdog cleared.
REQ-026 MOVE with target 0: no motion; move_en stays 0; ACK sent directly, -> TXW.
REQ-027 MOVE with target>0: move_en high from cycle after acceptance; -> MOVE.
REQ-028 MOVE: each sq_done increments 4-bit counter; on increment reaching target, move_en low next cycle, ACK sent, -> TXW.
REQ-029 Opcode 4'h6 (TOUR): tour_pos<=cmd[7:0], tour_go pulse cycle after acceptance, no response, -> IDLE.
REQ-030 Any other opcode: resp<=NAK, trmt pulse, -> TXW.
REQ-031 Watchdog: counts every cycle in CAL/MOVE; at all-ones: move_en low, resp<=NAK, trmt pulse, -> TXW.
REQ-032 Completion (cal_done or final sq_done) same cycle as watchdog expiry: completion wins, ACK.
REQ-033 cal_done outside CAL and sq_done outside MOVE ignored; counter unchanged.
REQ-034 TXW: resp held stable; on tx_done -> IDLE; tx_done in same cycle as trmt not possible, ignored if seen before trmt.
REQ-035 heading and tour_pos hold last value until next MOVE/TOUR command.
REQ-036 Exactly one trmt per CAL, MOVE or invalid command; exactly one clr_cmd_rdy per accepted command.
REQ-037 busy is high from cycle after acceptance until return to IDLE.

Reset
REQ-038 rst_n low: state IDLE; clr_cmd_rdy, trmt, strt_cal, move_en, tour_go, busy = 0; resp, heading, tour_pos = 8'h00; counters 0.
REQ-039 rst_n low mid-operation (any state): immediate abort to reset values; no trmt, no response after release.

Verification
REQ-040 cmd=16'h2000, cal_done 50 cycles later -> clr_cmd_rdy 1 cycle, strt_cal 1 cycle, trmt with resp=8'hA5, busy low after tx_done.
REQ-041 cmd=16'h45A3, three sq_done pulses -> heading=8'h5A, move_en high until cycle after third pulse, then resp=8'hA5 trmt.
REQ-042 cmd=16'h4120 -> move_en never high, resp=8'hA5 trmt immediately, heading=8'h12.
REQ-043 cmd=16'h6023 -> tour_pos=8'h23, tour_go 1 cycle, no trmt, busy low 1 cycle later.
REQ-044 cmd=16'hF000 -> resp=8'h5A trmt; TMO_W=6, MOVE count 2 with no sq_done -> after 63 cycles move_en low, resp=8'h5A.
REQ-045 second cmd_rdy during MOVE -> no clr_cmd_rdy until IDLE; rst_n pulse in MOVE -> move_en=0, no trmt.
